// File: rtl/arb_pkg.sv
// Shared types, sizes and the rotating-priority search for the 4-way round-robin arbiter.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;
  localparam int HOLD_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } gnt_t;

  // First set request at or above ptr, wrapping modulo NUM_REQ.
  // The loop runs downward so the lowest offset from ptr wins.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] pick;
    pick = ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ptr + IDX_W'(i);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/decoder2to4.sv
// Plain 2-to-4 one-hot decoder.
module decoder2to4 (
  input  logic A1,
  input  logic A0,
  output logic D0,
  output logic D1,
  output logic D2,
  output logic D3
);

  assign D0 = ~A1 & ~A0;
  assign D1 = ~A1 &  A0;
  assign D2 =  A1 & ~A0;
  assign D3 =  A1 &  A0;

endmodule

// File: rtl/arb4_rr_ctrl.sv
// 4-way round-robin arbiter with a per-grant hold limit and a forced dead cycle between grants.
module arb4_rr_ctrl
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               preempt
);

  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);

  arb_state_e        state_q,    state_d;
  logic [IDX_W-1:0]  ptr_q,      ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  gnt_t              gnt_q,      gnt_d;
  logic              preempt_q,  preempt_d;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    preempt_d  = 1'b0;
    unique case (state_q)
      IDLE, GAP: begin
        if (|req) begin
          gnt_d.idx  = rr_pick(req, ptr_q);
          gnt_d.vld  = 1'b1;
          hold_cnt_d = '0;
          state_d    = BUSY;
        end else begin
          gnt_d.vld = 1'b0;
          state_d   = IDLE;
        end
      end
      BUSY: begin
        // Release and limit share one path; only preempt tells them apart.
        if (!req[gnt_q.idx] || (hold_cnt_q == HOLD_LIM)) begin
          gnt_d.vld = 1'b0;
          ptr_d     = gnt_q.idx + IDX_W'(1);
          preempt_d = req[gnt_q.idx];
          state_d   = GAP;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: begin
        gnt_d.vld = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      preempt_q  <= preempt_d;
    end
  end

  logic [NUM_REQ-1:0] dec;

  decoder2to4 u_dec (
    .A1 (gnt_q.idx[1]),
    .A0 (gnt_q.idx[0]),
    .D0 (dec[0]),
    .D1 (dec[1]),
    .D2 (dec[2]),
    .D3 (dec[3])
  );

  assign gnt       = dec & {NUM_REQ{gnt_q.vld}};
  assign gnt_idx   = gnt_q.idx;
  assign gnt_valid = gnt_q.vld;
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_arb4_rr_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic vs. a grant-ownership model.
module tb_arb4_rr_ctrl;

  localparam int MH = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  int checks = 0;
  int errors = 0;

  arb4_rr_ctrl #(.MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: who owns the grant, how many cycles it has been visible, where the search starts.
  int m_owner = -1;
  int m_held  = 0;
  int m_ptr   = 0;
  int m_pre   = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_owner = -1; m_held = 0; m_ptr = 0; m_pre = 0;
    end else if (m_owner >= 0) begin
      if (!req[m_owner] || m_held == MH) begin
        m_pre   = req[m_owner] ? 1 : 0;
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
      end else begin
        m_held++;
        m_pre = 0;
      end
    end else begin
      m_pre = 0;
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && req[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
      end
      if (m_owner >= 0) m_held = 1;
    end
    #1;
    chk("onehot", ($countones(gnt) <= 1) ? 1 : 0, 1);
    chk("gnt_vs_idx", int'(gnt), gnt_valid ? (1 << gnt_idx) : 0);
    chk("valid_or", int'(gnt_valid), int'(|gnt));
    chk("model_gnt", int'(gnt), (m_owner >= 0) ? (1 << m_owner) : 0);
    chk("model_pre", int'(preempt), m_pre);
    if (m_owner >= 0) chk("model_idx", int'(gnt_idx), m_owner);
  end

  // Drive one edge's inputs, then return at the following falling edge.
  task automatic cyc(input logic [3:0] r, input logic rs);
    req   = r;
    rst_n = rs;
    @(negedge clk);
  endtask

  logic [3:0] r;
  logic       rs;

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    @(negedge clk);
    cyc(4'b0000, 1'b0);
    chk("rst_gnt",   int'(gnt), 0);
    chk("rst_valid", int'(gnt_valid), 0);
    chk("rst_idx",   int'(gnt_idx), 0);
    chk("rst_pre",   int'(preempt), 0);

    // Single requester held three edges, then dropped.
    for (int i = 0; i < 3; i++) begin
      cyc(4'b0100, 1'b1);
      chk("r2_hold", int'(gnt), 4);
    end
    cyc(4'b0000, 1'b1);
    chk("r2_gap_gnt", int'(gnt), 0);
    chk("r2_gap_pre", int'(preempt), 0);

    // Pointer now 3: 1001 must go to 3, then wrap to 0.
    cyc(4'b1001, 1'b1);
    chk("wrap_g3", int'(gnt), 8);
    chk("wrap_idx3", int'(gnt_idx), 3);
    cyc(4'b1001, 1'b1);
    chk("wrap_g3b", int'(gnt), 8);
    cyc(4'b0001, 1'b1);
    chk("wrap_gap", int'(gnt), 0);
    cyc(4'b0001, 1'b1);
    chk("wrap_g0", int'(gnt), 1);
    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b1);

    // One-cycle pulse from IDLE.
    cyc(4'b0001, 1'b1);
    chk("pulse_g0", int'(gnt), 1);
    cyc(4'b0000, 1'b1);
    chk("pulse_gap", int'(gnt), 0);
    chk("pulse_pre", int'(preempt), 0);
    cyc(4'b0000, 1'b1);
    chk("pulse_idle", int'(gnt), 0);

    // All four requesting: 8-cycle grants, 1 dead cycle with preempt, rotating 0,1,2,3,0.
    cyc(4'b0000, 1'b0);
    for (int k = 0; k < 40; k++) begin
      cyc(4'b1111, 1'b1);
      if (k % (MH + 1) < MH) begin
        chk("all_gnt", int'(gnt), 1 << ((k / (MH + 1)) % 4));
        chk("all_pre", int'(preempt), 0);
      end else begin
        chk("all_gap", int'(gnt), 0);
        chk("all_pre", int'(preempt), 1);
      end
    end
    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b1);

    // Reset mid-grant to index 2, then 0110 must go to 1.
    cyc(4'b0100, 1'b1);
    chk("mid_g2", int'(gnt), 4);
    cyc(4'b0100, 1'b1);
    cyc(4'b0100, 1'b0);
    chk("mid_rst_gnt",   int'(gnt), 0);
    chk("mid_rst_valid", int'(gnt_valid), 0);
    chk("mid_rst_pre",   int'(preempt), 0);
    cyc(4'b0110, 1'b1);
    chk("mid_after_g1", int'(gnt), 2);
    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b1);

    // Randomized traffic with sticky requests and rare resets.
    r = 4'b0000;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 11) == 0) r[$urandom_range(0, 3)] = 1'b0;
      rs = ($urandom_range(0, 149) != 0);
      cyc(r, rs);
    end

    cyc(4'b0000, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arb4_rr_ctrl.md
ARB4_RR_CTRL -- requirements
Module: arb4_rr_ctrl

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 8, meaning the maximum consecutive cycles one requester may hold the grant; legal range is 2..255.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 SHALL have port req, input, 4 bits: request lines; bit i is requester i, level-sensitive.
REQ-005 SHALL have port gnt, output, 4 bits: one-hot grant, or all-zero.
REQ-006 SHALL have port gnt_idx, output, 2 bits: index of the current grant; valid only while gnt_valid=1.
REQ-007 SHALL have port gnt_valid, output, 1 bit: high while any grant is asserted.
REQ-008 SHALL have port preempt, output, 1 bit: one-cycle pulse when a grant is revoked by the MAX_HOLD limit.

Function
REQ-009 SHALL implement the FSM states IDLE, BUSY and GAP, with all outputs registered.
REQ-010 IDLE or GAP: if any req bit is set at edge N, SHALL grant the first set bit searching upward from ptr, modulo 4; gnt, gnt_idx and gnt_valid become visible after edge N; hold_cnt is cleared to 0; the next state is BUSY.
REQ-011 IDLE or GAP with req=0: next state SHALL be IDLE, and gnt SHALL be 0.
REQ-012 BUSY: while req[gnt_idx]=1 and hold_cnt<MAX_HOLD-1, the block SHALL hold the grant and increment hold_cnt.
REQ-013 BUSY, release (req[gnt_idx]=0): at that edge the block SHALL clear gnt and gnt_valid, set ptr=gnt_idx+1 mod 4, and go to GAP; preempt SHALL stay 0.
REQ-014 BUSY, limit (req[gnt_idx]=1 and hold_cnt=MAX_HOLD-1): the block SHALL behave as in REQ-013 and also pulse preempt for exactly one cycle. A grant therefore lasts at most MAX_HOLD cycles.
REQ-015 GAP SHALL last exactly one cycle with gnt=0, which guarantees a dead cycle between any two grants.
REQ-016 Requests on non-granted lines SHALL be ignored during BUSY and SHALL have no effect on hold_cnt.
REQ-017 Simultaneous requests SHALL be resolved only by the rotating priority from ptr; no requester may be granted twice while another requester is continuously requesting.
REQ-018 ptr wrap-around: after a grant to index 3, ptr SHALL become 0.
REQ-019 hold_cnt SHALL be 8 bits wide, unsigned, and never wrap; saturation is impossible given REQ-014.
REQ-020 gnt SHALL equal the decode of gnt_idx ANDed with gnt_valid, with no combinational path from req to gnt.

Reset
REQ-021 With rst_n=0 at an edge, the block SHALL enter state IDLE and set ptr=0, hold_cnt=0, gnt=4'b0000, gnt_idx=2'b00, gnt_valid=0 and preempt=0.
REQ-022 A reset asserted mid-grant SHALL drop gnt at that same edge, with no GAP cycle and no preempt pulse.
REQ-023 On the first edge after rst_n returns to 1, the block SHALL arbitrate normally from ptr=0.

Structure
REQ-024 Package arb_pkg SHALL hold the state enum (IDLE, BUSY, GAP), NUM_REQ=4, and IDX_W=2.
REQ-025 The block SHALL instantiate the existing decoder2to4 sub-module, with inputs A1/A0 = gnt_idx[1]/gnt_idx[0] and outputs D0..D3 gated by gnt_valid to form gnt[0..3].
REQ-026 The priority search SHALL be a single function placed in arb_pkg.

Verification
REQ-027 The bench SHALL cover: reset, then req=4'b0100 held for 3 cycles then dropped -> gnt=4'b0100 for 3 cycles, then 1 GAP cycle, then ptr=3.
REQ-028 The bench SHALL cover: req=4'b1111 held for 40 cycles with MAX_HOLD=8 -> grants in order 0,1,2,3,0, each 8 cycles long, separated by 1 GAP cycle, with a preempt pulse at each handoff.
REQ-029 The bench SHALL cover: ptr=3 with req=4'b1001 -> grant to index 3; after its release, grant to index 0 (wrap-around).
REQ-030 The bench SHALL cover: rst_n=0 during a grant to index 2 -> at that edge gnt=0, gnt_valid=0 and preempt=0; after release the next grant, for req=4'b0110, goes to index 1.
REQ-031 The bench SHALL cover: req=4'b0001 pulsed for 1 cycle from IDLE -> gnt=4'b0001 for exactly 1 cycle, then GAP, then IDLE with gnt=0.
REQ-032 The bench SHALL check on every cycle: gnt is one-hot or zero, gnt matches the decode of gnt_idx, and gnt_valid equals the OR of gnt.
